hex_display_scheduler: RTL and testbench

- Drives the board's six 7-segment digits from one 24-bit hex value.
- Time-shares a single hex_to_7seg decoder across all digit positions, scanning MSD to LSD into a shadow register.
- Commits all six digits to the pins in one cycle, so the display never shows a partial update.
- Enforces a minimum hold time between updates and keeps one pending value (newest wins), which rate-limits display churn from fast producers such as sensor readouts.

---
 rtl/hex_display_scheduler_pkg.sv | 15 +
 rtl/hex_to_7seg.sv | 30 +++
 rtl/hex_display_scheduler.sv | 159 +++++++++++++++
 tb/tb_hex_display_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_scheduler_pkg.sv
// Shared types and constants for the six-digit hex display scheduler.
package hex_display_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // 50 ms between commits at the 50 MHz board clock
  localparam int HOLD_CYCLES_50MHZ = 2500000;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to low-active 7-segment decoder, segments ordered {g..a}.
module hex_to_7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// Scans a hex value MSD-first through one shared decoder into a shadow register,
// commits all digits at once, then holds the display with a one-deep newest-wins pending slot.
module hex_display_scheduler
  import hex_display_scheduler_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int HOLD_CYCLES = HOLD_CYCLES_50MHZ
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_en,
  input  logic                    load,
  output logic [8*NUM_DIGITS-1:0] seg_out,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int HCW   = $clog2(HOLD_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_MSD   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [HCW-1:0]   HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  state_t state, state_next;

  logic [IDX_W-1:0]        idx;
  logic                    lz;
  logic [HCW-1:0]          hold_cnt;
  logic [4*NUM_DIGITS-1:0] work_val, pend_val;
  logic [NUM_DIGITS-1:0]   work_dp, pend_dp;
  logic                    work_blank, pend_blank, pend_valid;
  logic [8*NUM_DIGITS-1:0] shadow, shadow_next;

  logic [3:0] nibble;
  logic [6:0] dec_seg;
  logic [7:0] digit_byte;
  logic       digit_blank;
  logic       expire, take_load, take_pend, pend_write, commit, overrun_next;

  hex_to_7seg u_dec (
    .hex (nibble),
    .seg (dec_seg)
  );

  // Datapath for the digit currently under the scan pointer
  always_comb begin
    nibble      = work_val[4*idx +: 4];
    digit_blank = work_blank && lz && (idx != '0) && (nibble == 4'h0);
    digit_byte  = digit_blank ? SEG_BLANK : {~work_dp[idx], dec_seg};
    shadow_next = shadow;
    if (state == SCAN) shadow_next[8*idx +: 8] = digit_byte;
  end

  always_comb begin
    state_next   = state;
    take_load    = 1'b0;
    take_pend    = 1'b0;
    pend_write   = 1'b0;
    commit       = 1'b0;
    overrun_next = 1'b0;
    expire       = (state == HOLD) && (hold_cnt == HOLD_LAST);
    case (state)
      IDLE: begin
        if (load) begin
          take_load  = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        pend_write = load;
        if (idx == '0) begin
          commit     = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        // A load landing on the expiry cycle bypasses the pending slot entirely
        if (expire) begin
          if (load) begin
            take_load    = 1'b1;
            overrun_next = pend_valid;
            state_next   = SCAN;
          end else if (pend_valid) begin
            take_pend  = 1'b1;
            state_next = SCAN;
          end else begin
            state_next = IDLE;
          end
        end else begin
          pend_write = load;
        end
      end
      default: state_next = IDLE;
    endcase
    if (pend_write && pend_valid) overrun_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      lz         <= 1'b1;
      hold_cnt   <= '0;
      work_val   <= '0;
      work_dp    <= '0;
      work_blank <= 1'b0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_blank <= 1'b0;
      pend_valid <= 1'b0;
      shadow     <= '1;
      seg_out    <= '1;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (take_load) begin
        work_val   <= value_in;
        work_dp    <= dp_in;
        work_blank <= blank_en;
      end else if (take_pend) begin
        work_val   <= pend_val;
        work_dp    <= pend_dp;
        work_blank <= pend_blank;
      end

      if (take_load || take_pend) begin
        idx <= IDX_MSD;
        lz  <= 1'b1;
      end else if (state == SCAN) begin
        idx <= idx - 1'b1;
        lz  <= lz && digit_blank;
      end

      if (pend_write) begin
        pend_val   <= value_in;
        pend_dp    <= dp_in;
        pend_blank <= blank_en;
        pend_valid <= 1'b1;
      end else if (take_load || take_pend) begin
        pend_valid <= 1'b0;
      end

      hold_cnt <= (state == HOLD && !expire) ? hold_cnt + 1'b1 : '0;
      shadow   <= shadow_next;
      if (commit) seg_out <= shadow_next;
      done     <= commit;
      overrun  <= overrun_next;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler with a scoreboard of expected commits.
module tb_hex_display_scheduler;

  localparam int ND = 6;
  localparam int HC = 20;
  localparam logic [7:0] SEG_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [23:0]   value_in = '0;
  logic [5:0]    dp_in = '0;
  logic          blank_en = 1'b0;
  logic          load = 1'b0;
  logic [47:0]   seg_out;
  logic          busy, done, overrun;

  int n_cmp = 0;
  int n_bad = 0;
  logic [47:0] exp_q[$];

  hex_display_scheduler #(.NUM_DIGITS(ND), .HOLD_CYCLES(HC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value_in (value_in),
    .dp_in    (dp_in),
    .blank_en (blank_en),
    .load     (load),
    .seg_out  (seg_out),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] model(logic [23:0] v, logic [5:0] dp, logic blank);
    logic [47:0] r;
    logic        lz;
    logic [3:0]  nib;
    logic [7:0]  b;
    r  = '1;
    lz = 1'b1;
    for (int i = ND - 1; i >= 0; i--) begin
      nib = v[4*i +: 4];
      if (blank && lz && i != 0 && nib == 4'h0) begin
        r[8*i +: 8] = 8'hFF;
      end else begin
        b = SEG_TAB[nib];
        r[8*i +: 8] = {~dp[i], b[6:0]};
        lz = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string tag, logic [47:0] obs, logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkFlag(string tag, logic obs, logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle load; replaces=1 means it supersedes a queued pending value
  task automatic applyStimulus(logic [23:0] v, logic [5:0] dp, logic blank, bit replaces);
    if (replaces && exp_q.size() > 0) void'(exp_q.pop_back());
    exp_q.push_back(model(v, dp, blank));
    value_in = v;
    dp_in    = dp;
    blank_en = blank;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    value_in = 24'($urandom);
    dp_in    = 6'($urandom);
    blank_en = 1'($urandom);
  endtask

  // Entered in the first SCAN cycle; returns in the commit cycle
  task automatic expectCommit(string tag);
    logic [47:0] held;
    logic [47:0] exp;
    held = seg_out;
    for (int i = 1; i <= ND; i++) begin
      checkFlag({tag, " done early"}, done, 1'b0);
      checkFlag({tag, " busy in scan"}, busy, 1'b1);
      checkOutput({tag, " held"}, seg_out, held);
      tick();
    end
    checkFlag({tag, " done"}, done, 1'b1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("[TB] FAIL %s scoreboard: observed %h, expected nothing queued", tag, seg_out);
    end else begin
      exp = exp_q.pop_front();
      checkOutput({tag, " seg_out"}, seg_out, exp);
    end
  endtask

  task automatic waitIdle(string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    checkFlag({tag, " reaches idle"}, busy, 1'b0);
  endtask

  initial begin
    $display("[TB] start");
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset seg_out", seg_out, '1);
    checkFlag("reset busy", busy, 1'b0);
    checkFlag("reset done", done, 1'b0);
    checkFlag("reset overrun", overrun, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Basic decode with exact latency and busy window
    applyStimulus(24'h123456, 6'b0, 1'b0, 1'b0);
    expectCommit("basic");
    tick();
    checkFlag("basic done single", done, 1'b0);
    for (int c = 8; c <= 6 + HC; c++) begin
      checkFlag("basic busy in hold", busy, 1'b1);
      tick();
    end
    checkFlag("basic busy after hold", busy, 1'b0);

    applyStimulus(24'h0000A0, 6'b0, 1'b1, 1'b0);
    expectCommit("blank interior");
    waitIdle("blank interior");
    applyStimulus(24'h000000, 6'b0, 1'b1, 1'b0);
    expectCommit("blank all zero");
    waitIdle("blank all zero");
    applyStimulus(24'h000001, 6'b000010, 1'b0, 1'b0);
    expectCommit("decimal point");
    waitIdle("decimal point");

    // Pending slot overwritten while holding; only the newest is shown
    applyStimulus(24'h111111, 6'b0, 1'b0, 1'b0);
    expectCommit("pend first");
    repeat (3) tick();
    applyStimulus(24'h222222, 6'b0, 1'b0, 1'b0);
    checkFlag("pend no overrun", overrun, 1'b0);
    tick();
    applyStimulus(24'h333333, 6'b0, 1'b0, 1'b1);
    checkFlag("pend overrun", overrun, 1'b1);
    tick();
    checkFlag("pend overrun single", overrun, 1'b0);
    repeat (13) tick();
    expectCommit("pend newest");
    waitIdle("pend newest");

    // Display stays intact during a scan, then reset abandons a scan
    applyStimulus(24'hFFFFFF, 6'b0, 1'b0, 1'b0);
    expectCommit("tear setup");
    waitIdle("tear setup");
    applyStimulus(24'h000000, 6'b0, 1'b0, 1'b0);
    expectCommit("no tearing");
    waitIdle("no tearing");
    applyStimulus(24'h654321, 6'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("async reset seg_out", seg_out, '1);
    checkFlag("async reset busy", busy, 1'b0);
    checkFlag("async reset done", done, 1'b0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkFlag("post reset done", done, 1'b0);
      checkOutput("post reset seg_out", seg_out, '1);
    end

    // Load on the final hold cycle with a pending value already queued
    applyStimulus(24'hABCDEF, 6'b0, 1'b0, 1'b0);
    expectCommit("expiry first");
    repeat (3) tick();
    applyStimulus(24'h111111, 6'b0, 1'b0, 1'b0);
    repeat (15) tick();
    applyStimulus(24'h987654, 6'b0, 1'b0, 1'b1);
    checkFlag("expiry overrun", overrun, 1'b1);
    expectCommit("expiry load");
    checkFlag("expiry overrun single", overrun, 1'b0);
    waitIdle("expiry load");

    checkFlag("scoreboard drained", exp_q.size() == 0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
